// File: rtl/axis_frame_rr_arb.sv
// axis_frame_rr_arb
// Frame-granular round-robin arbiter: several AXI-Stream sources share one
// master port. Ownership is taken at the first beat and released on the
// tlast beat, so frames never interleave. Frames longer than MAX_BEATS are
// cut with a forced tlast and flagged in a sticky error bit.
module axis_frame_rr_arb #(
  parameter int W         = 32,
  parameter int N_SRC     = 2,
  parameter int MAX_BEATS = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC*W-1:0] s_axis_tdata,
  input  logic [N_SRC-1:0]   s_axis_tvalid,
  output logic [N_SRC-1:0]   s_axis_tready,
  input  logic [N_SRC-1:0]   s_axis_tlast,
  output logic [W-1:0]       m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic [N_SRC-1:0]   grant,
  output logic [15:0]        frame_cnt,
  output logic               oversize_err
);

  // Owner index width and beat counter width. The beat counter only has to
  // reach MAX_BEATS-1: the beat at that count always ends the frame.
  localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int BW = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
  localparam logic [BW-1:0] BEAT_CAP = BW'(MAX_BEATS - 1);
  localparam logic [GW:0]   N_WRAP   = (GW + 1)'(N_SRC);

  typedef enum logic {
    ST_IDLE,
    ST_PASS
  } st_t;

  st_t           st_q, st_d;
  logic [GW-1:0] g_q, g_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          err_q, err_d;

  logic [W-1:0]  src_data [N_SRC];
  logic          any_req;
  logic [GW-1:0] pick;
  logic          cap_hit;
  logic          beat;

  // Split the flat source data bus into one word per source.
  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign src_data[i] = s_axis_tdata[i*W +: W];
  end

  // Round-robin pick: scan ptr+1, ptr+2, ... so the last owner comes last.
  always_comb begin
    logic [GW:0] sum;
    any_req = 1'b0;
    pick    = '0;
    sum     = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      sum = {1'b0, ptr_q} + (GW + 1)'(k);
      if (sum >= N_WRAP) begin
        sum = sum - N_WRAP;
      end
      if (!any_req && s_axis_tvalid[sum[GW-1:0]]) begin
        any_req = 1'b1;
        pick    = sum[GW-1:0];
      end
    end
  end

  assign cap_hit = (beat_q == BEAT_CAP);

  // Master/slave handshake mux: purely combinational while a source owns the port.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    grant         = '0;
    if (st_q == ST_PASS) begin
      m_axis_tvalid    = s_axis_tvalid[g_q];
      m_axis_tdata     = src_data[g_q];
      m_axis_tlast     = s_axis_tlast[g_q] | cap_hit;
      s_axis_tready[g_q] = m_axis_tready;
      grant[g_q]       = 1'b1;
    end
  end

  assign beat = m_axis_tvalid & m_axis_tready;

  // Next-state: arbitrate in IDLE, count beats and close frames in PASS.
  always_comb begin
    st_d   = st_q;
    g_d    = g_q;
    ptr_d  = ptr_q;
    beat_d = beat_q;
    fcnt_d = fcnt_q;
    err_d  = err_q;
    case (st_q)
      ST_IDLE: begin
        if (any_req) begin
          st_d   = ST_PASS;
          g_d    = pick;
          ptr_d  = pick;
          beat_d = '0;
        end
      end
      ST_PASS: begin
        if (beat) begin
          if (m_axis_tlast) begin
            // Closing beat; a source tlast landing on the cap is a normal end.
            fcnt_d = fcnt_q + 16'd1;
            st_d   = ST_IDLE;
            if (cap_hit && !s_axis_tlast[g_q]) begin
              err_d = 1'b1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  // State registers; ptr resets to the last source so source 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      g_q    <= '0;
      ptr_q  <= GW'(N_SRC - 1);
      beat_q <= '0;
      fcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      g_q    <= g_d;
      ptr_q  <= ptr_d;
      beat_q <= beat_d;
      fcnt_q <= fcnt_d;
      err_q  <= err_d;
    end
  end

  assign frame_cnt    = fcnt_q;
  assign oversize_err = err_q;

endmodule

// File: tb/tb_axis_frame_rr_arb.sv
// tb_axis_frame_rr_arb
// Two arbiter instances: A with the default 256-beat cap, B with an 8-beat
// cap for truncation cases. Expected master beats are queued per instance
// and compared as the master handshakes occur.
module tb_axis_frame_rr_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Source lanes 0,1 feed instance A; lanes 2,3 feed instance B.
  logic [31:0] sd [4];
  logic        sv [4];
  logic        sl [4];
  logic        a_mready, b_mready;

  logic [63:0] a_sdata, b_sdata;
  logic [1:0]  a_svalid, b_svalid, a_slast, b_slast, a_sready, b_sready;
  logic [31:0] a_mdata, b_mdata;
  logic        a_mvalid, b_mvalid, a_mlast, b_mlast, a_err, b_err;
  logic [1:0]  a_grant, b_grant;
  logic [15:0] a_fcnt, b_fcnt;
  logic [3:0]  rdy;

  assign a_sdata  = {sd[1], sd[0]};
  assign b_sdata  = {sd[3], sd[2]};
  assign a_svalid = {sv[1], sv[0]};
  assign b_svalid = {sv[3], sv[2]};
  assign a_slast  = {sl[1], sl[0]};
  assign b_slast  = {sl[3], sl[2]};
  assign rdy      = {b_sready, a_sready};

  axis_frame_rr_arb #(.W(32), .N_SRC(2), .MAX_BEATS(256)) dut_a (
    .clk(clk), .rst(rst),
    .s_axis_tdata(a_sdata), .s_axis_tvalid(a_svalid), .s_axis_tready(a_sready),
    .s_axis_tlast(a_slast),
    .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid), .m_axis_tready(a_mready),
    .m_axis_tlast(a_mlast),
    .grant(a_grant), .frame_cnt(a_fcnt), .oversize_err(a_err)
  );

  axis_frame_rr_arb #(.W(32), .N_SRC(2), .MAX_BEATS(8)) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(b_sdata), .s_axis_tvalid(b_svalid), .s_axis_tready(b_sready),
    .s_axis_tlast(b_slast),
    .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready),
    .m_axis_tlast(b_mlast),
    .grant(b_grant), .frame_cnt(b_fcnt), .oversize_err(b_err)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [1:0]  g;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int a_last_cyc = 0;
  int a_gap = 0;
  logic a_prev_last = 1'b0;
  logic t4_on = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int which, input logic [31:0] d, input logic l, input logic [1:0] g);
    exp_t e;
    e.d = d;
    e.l = l;
    e.g = g;
    if (which == 0) qa.push_back(e);
    else            qb.push_back(e);
  endtask

  // Present one beat on a lane and hold it until the DUT accepts it.
  task automatic send_beat(input int src, input logic [31:0] d, input logic l);
    int n;
    n = 0;
    sv[src] = 1'b1;
    sd[src] = d;
    sl[src] = l;
    @(negedge clk);
    while (!rdy[src] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("beat_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    sv[src] = 1'b0;
    sl[src] = 1'b0;
  endtask

  task automatic send_frames(input int src, input int nf, input int nb, input logic [31:0] base);
    for (int f = 0; f < nf; f++) begin
      for (int k = 0; k < nb; k++) begin
        send_beat(src, base | (f << 8) | k, (k == nb - 1));
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Toggle A's downstream ready every cycle while enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (t4_on) a_mready = ~a_mready;
  end

  // Monitor A: every master handshake is checked against the queue head.
  initial forever begin
    @(negedge clk);
    if (!rst && a_mvalid && a_mready) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_beat", {32'd0, a_mdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("a_data", a_mdata, qa[0].d);
        chk("a_last", a_mlast, qa[0].l);
        chk("a_grant", a_grant, qa[0].g);
        void'(qa.pop_front());
      end
      if (a_prev_last) a_gap = cyc - a_last_cyc;
      a_prev_last = a_mlast;
      if (a_mlast) a_last_cyc = cyc;
    end
  end

  // Monitor B.
  initial forever begin
    @(negedge clk);
    if (!rst && b_mvalid && b_mready) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_beat", {32'd0, b_mdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("b_data", b_mdata, qb[0].d);
        chk("b_last", b_mlast, qb[0].l);
        chk("b_grant", b_grant, qb[0].g);
        void'(qb.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_mready = 1'b1;
    b_mready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sd[i] = '0;
      sv[i] = 1'b0;
      sl[i] = 1'b0;
    end

    // T1: reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_grant", a_grant, 2'b00);
    chk("t1_mvalid", a_mvalid, 1'b0);
    chk("t1_sready", a_sready, 2'b00);
    chk("t1_fcnt", a_fcnt, 16'd0);
    chk("t1_err", a_err, 1'b0);
    chk("t1_b_grant", b_grant, 2'b00);
    chk("t1_b_err", b_err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // T2: two concurrent sources, three 4-beat frames each, strict alternation
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < 2; s++)
        for (int k = 0; k < 4; k++)
          push_exp(0, 32'hA000_0000 | (s << 16) | (f << 8) | k, (k == 3), 2'(1 << s));
    fork
      send_frames(0, 3, 4, 32'hA000_0000);
      send_frames(1, 3, 4, 32'hA001_0000);
    join
    chk("t2_fcnt", a_fcnt, 16'd6);

    // T3: lone src1, back-to-back 2-beat frames, exactly one idle cycle
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 2; k++)
        push_exp(0, 32'h3000_0000 | (f << 8) | k, (k == 1), 2'b10);
    send_frames(1, 2, 2, 32'h3000_0000);
    chk("t3_gap", a_gap, 2);
    chk("t3_fcnt", a_fcnt, 16'd2);

    // T4: 32-beat frame under toggling downstream ready
    do_reset();
    for (int k = 0; k < 32; k++)
      push_exp(0, 32'h1111_0000 + k, (k == 31), 2'b01);
    a_mready = 1'b1;
    t4_on = 1'b1;
    for (int k = 0; k < 32; k++)
      send_beat(0, 32'h1111_0000 + k, (k == 31));
    t4_on = 1'b0;
    @(negedge clk);
    a_mready = 1'b1;
    chk("t4_fcnt", a_fcnt, 16'd1);
    chk("t4_err", a_err, 1'b0);

    // T6: reset mid-frame, then a fresh frame
    do_reset();
    push_exp(0, 32'h6600_0000, 1'b0, 2'b01);
    push_exp(0, 32'h6600_0001, 1'b0, 2'b01);
    send_beat(0, 32'h6600_0000, 1'b0);
    send_beat(0, 32'h6600_0001, 1'b0);
    sv[0] = 1'b1;
    sd[0] = 32'h6600_0002;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_grant", a_grant, 2'b00);
    chk("t6_mvalid", a_mvalid, 1'b0);
    chk("t6_sready", a_sready, 2'b00);
    chk("t6_fcnt_rst", a_fcnt, 16'd0);
    sv[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++)
      push_exp(0, 32'h6700_0000 + k, (k == 2), 2'b01);
    for (int k = 0; k < 3; k++)
      send_beat(0, 32'h6700_0000 + k, (k == 2));
    chk("t6_fcnt", a_fcnt, 16'd1);

    // T5: B with 8-beat cap, 10-beat frame -> truncated at 8, tail is a new frame
    do_reset();
    for (int k = 0; k < 10; k++)
      push_exp(1, 32'h5500_0000 + k, (k == 7) || (k == 9), 2'b01);
    for (int k = 0; k < 10; k++) begin
      send_beat(2, 32'h5500_0000 + k, (k == 9));
      if (k == 6) chk("t5_err_before", b_err, 1'b0);
      if (k == 7) chk("t5_err_after", b_err, 1'b1);
    end
    chk("t5_fcnt", b_fcnt, 16'd2);
    chk("t5_err_sticky", b_err, 1'b1);

    // T5b: source tlast exactly on the cap is a normal end
    do_reset();
    for (int k = 0; k < 8; k++)
      push_exp(1, 32'h5600_0000 + k, (k == 7), 2'b01);
    for (int k = 0; k < 8; k++)
      send_beat(2, 32'h5600_0000 + k, (k == 7));
    chk("t5b_err", b_err, 1'b0);
    chk("t5b_fcnt", b_fcnt, 16'd1);

    repeat (3) @(posedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
